// File: rtl/sram_master_ctrl.sv
// Initiator-side sequencer for a single-port RAM (cs/wr/oe/address/data).
// Accepts single or burst host requests and drives registered RAM pins cycle by cycle.
// Write beats stream in on a valid/ready handshake; read beats return as rdata_valid pulses.
module sram_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [ADDR_SIZE-1:0]  req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  cs,
  output logic                  wr,
  output logic                  oe,
  output logic [ADDR_SIZE-1:0]  address,
  inout  wire  [DATA_WIDTH-1:0] data
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdAddr,
    StRdData,
    StTurn
  } state_t;

  state_t                state_q;
  logic [ADDR_SIZE-1:0]  cur_addr_q;
  logic [ADDR_SIZE-1:0]  cnt_q;
  logic                  drv_en_q;
  logic [DATA_WIDTH-1:0] dout_q;

  // Next burst address, wrapping at the top of the RAM.
  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    addr_inc = ADDR_SIZE'((32'(a) + 32'd1) % DEPTH);
  endfunction

  // Host-side status decoded straight from the state register.
  assign req_ready   = (state_q == StIdle) && !rst;
  assign wdata_ready = (state_q == StWr);
  assign busy        = (state_q != StIdle);

  // The master only drives the bus from its own registered enable.
  assign data = drv_en_q ? dout_q : {DATA_WIDTH{1'bz}};

  // Sequencer: state plus every RAM pin is registered here, so host inputs never reach pins
  // combinationally. Pin values are set on entry to the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      drv_en_q    <= 1'b0;
      dout_q      <= '0;
      cs          <= 1'b0;
      wr          <= 1'b0;
      oe          <= 1'b0;
      address     <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      rdata_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cs       <= 1'b0;
          wr       <= 1'b0;
          oe       <= 1'b0;
          drv_en_q <= 1'b0;
          if (req_valid) begin
            cur_addr_q <= req_addr;
            cnt_q      <= req_len;
            if (req_wr) begin
              state_q <= StWr;
            end else begin
              // First address phase starts right away.
              state_q <= StRdAddr;
              cs      <= 1'b1;
              address <= req_addr;
            end
          end
        end
        StWr: begin
          oe <= 1'b0;
          if (wdata_valid) begin
            cs         <= 1'b1;
            wr         <= 1'b1;
            address    <= cur_addr_q;
            dout_q     <= wdata;
            drv_en_q   <= 1'b1;
            cur_addr_q <= addr_inc(cur_addr_q);
            if (cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end else begin
            // Stall: deselect so no write happens this cycle.
            cs       <= 1'b0;
            wr       <= 1'b0;
            drv_en_q <= 1'b0;
          end
        end
        StRdAddr: begin
          cs       <= 1'b1;
          wr       <= 1'b0;
          oe       <= 1'b1;
          drv_en_q <= 1'b0;
          state_q  <= StRdData;
        end
        StRdData: begin
          rdata       <= data;
          rdata_valid <= 1'b1;
          oe          <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q      <= cnt_q - 1'b1;
            cur_addr_q <= addr_inc(cur_addr_q);
            address    <= addr_inc(cur_addr_q);
            cs         <= 1'b1;
            state_q    <= StRdAddr;
          end else begin
            cs      <= 1'b0;
            state_q <= StTurn;
          end
        end
        StTurn: begin
          // One idle bus cycle so the RAM releases data before the master may drive it.
          cs      <= 1'b0;
          oe      <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
